// File: rtl/fta_reqarb.sv
// Priority/round-robin request arbiter with per-channel outstanding tracking.
// Define FTA_REQARB_AGING_EN to compile in starvation aging (age 15 outranks any priority).
module fta_reqarb #(
  parameter int CHANNELS = 4,
  parameter int MAXOUT   = 4,
  localparam int HBIT    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   req_i,
  input  logic [4*CHANNELS-1:0] pri_i,
  input  logic                  bus_stall_i,
  input  logic                  resp_ack_i,
  input  logic [HBIT-1:0]       resp_ch_i,
  output logic [CHANNELS-1:0]   gnt_o,
  output logic [HBIT-1:0]       gnt_ch_o,
  output logic                  cyc_o,
  output logic [CHANNELS-1:0]   ack_o,
  output logic [CHANNELS-1:0]   full_o,
  output logic                  err_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [3:0]          outstanding [CHANNELS];
  logic [HBIT-1:0]     last_ch;
  logic [CHANNELS-1:0] elig;
  logic [4:0]          eff_pri [CHANNELS];
  logic                sel_vld;
  logic [HBIT-1:0]     sel_ch;
  logic [HBIT-1:0]     scan_ch;
  logic [4:0]          best_pri;
  logic                accept;

`ifdef FTA_REQARB_AGING_EN
  logic [3:0] age [CHANNELS];

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  assign accept = (state == GRANT) && !bus_stall_i;

  // A channel is not eligible in the cycle its ack is still visible.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      elig[n]    = req_i[n] && (outstanding[n] < 4'(MAXOUT)) && !ack_o[n];
      eff_pri[n] = {1'b0, pri_i[4*n +: 4]};
`ifdef FTA_REQARB_AGING_EN
      if (age[n] == 4'hF) eff_pri[n] = 5'd16;
`endif
      full_o[n]  = (outstanding[n] == 4'(MAXOUT));
    end
  end

  // Scan in round-robin order from last+1; strict '>' keeps the earliest on ties.
  always_comb begin
    sel_vld  = 1'b0;
    sel_ch   = '0;
    best_pri = '0;
    scan_ch  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      scan_ch = last_ch + HBIT'(i + 1);
      if (elig[scan_ch] && (!sel_vld || (eff_pri[scan_ch] > best_pri))) begin
        sel_vld  = 1'b1;
        sel_ch   = scan_ch;
        best_pri = eff_pri[scan_ch];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = GRANT;
      GRANT:   if (!bus_stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_o    <= '0;
      gnt_ch_o <= '0;
      cyc_o    <= 1'b0;
      ack_o    <= '0;
      last_ch  <= HBIT'(CHANNELS - 1);
      err_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_o <= '0;
      if (state == IDLE) begin
        if (sel_vld) begin
          gnt_o    <= CHANNELS'(1) << sel_ch;
          gnt_ch_o <= sel_ch;
          cyc_o    <= 1'b1;
        end else begin
          gnt_o <= '0;
          cyc_o <= 1'b0;
        end
      end else if (accept) begin
        ack_o   <= gnt_o;
        last_ch <= gnt_ch_o;
        gnt_o   <= '0;
        cyc_o   <= 1'b0;
      end
      if (resp_ack_i && (outstanding[resp_ch_i] == 4'd0)) err_o <= 1'b1;
    end
  end

  // Accept and retire on the same channel cancel out.
  always_ff @(posedge clk) begin
    for (int n = 0; n < CHANNELS; n++) begin
      if (rst) begin
        outstanding[n] <= 4'd0;
      end else begin
        if (accept && (gnt_ch_o == HBIT'(n))) begin
          if (!(resp_ack_i && (resp_ch_i == HBIT'(n))))
            outstanding[n] <= outstanding[n] + 4'd1;
        end else if (resp_ack_i && (resp_ch_i == HBIT'(n)) && (outstanding[n] != 4'd0)) begin
          outstanding[n] <= outstanding[n] - 4'd1;
        end
      end
    end
  end

`ifdef FTA_REQARB_AGING_EN
  always_ff @(posedge clk) begin
    for (int n = 0; n < CHANNELS; n++) begin
      if (rst) begin
        age[n] <= 4'd0;
      end else if (accept && (gnt_ch_o == HBIT'(n))) begin
        age[n] <= 4'd0;
      end else if ((state == IDLE) && sel_vld && elig[n] && (sel_ch != HBIT'(n))) begin
        age[n] <= sat_inc4(age[n]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fta_reqarb.sv
// Directed bench for fta_reqarb: a default instance plus a MAXOUT=2 instance on shared inputs.
module tb_fta_reqarb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic [15:0] pri_i;
  logic       bus_stall_i;
  logic       resp_ack_i;
  logic [1:0] resp_ch_i;

  logic [3:0] gnt_o, ack_o, full_o;
  logic [1:0] gnt_ch_o;
  logic       cyc_o, err_o;

  logic [3:0] gnt2, ack2, full2;
  logic [1:0] gnt_ch2;
  logic       cyc2, err2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fta_reqarb dut (
    .clk(clk), .rst(rst), .req_i(req_i), .pri_i(pri_i), .bus_stall_i(bus_stall_i),
    .resp_ack_i(resp_ack_i), .resp_ch_i(resp_ch_i), .gnt_o(gnt_o), .gnt_ch_o(gnt_ch_o),
    .cyc_o(cyc_o), .ack_o(ack_o), .full_o(full_o), .err_o(err_o)
  );

  fta_reqarb #(.CHANNELS(4), .MAXOUT(2)) dut2 (
    .clk(clk), .rst(rst), .req_i(req_i), .pri_i(pri_i), .bus_stall_i(bus_stall_i),
    .resp_ack_i(resp_ack_i), .resp_ch_i(resp_ch_i), .gnt_o(gnt2), .gnt_ch_o(gnt_ch2),
    .cyc_o(cyc2), .ack_o(ack2), .full_o(full2), .err_o(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0; pri_i = '0; bus_stall_i = 1'b0;
    resp_ack_i = 1'b0; resp_ch_i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 4'b1111; pri_i = '0; bus_stall_i = 1'b0;
    resp_ack_i = 1'b0; resp_ch_i = '0;
    tick(); tick();
    n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    n_cmp++; if (cyc_o !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b want 0", cyc_o); end
    n_cmp++; if (ack_o !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (full_o !== 4'b0000) begin n_bad++; $display("FAIL reset_full: got %b want 0000", full_o); end
    n_cmp++; if (gnt_ch_o !== 2'd0) begin n_bad++; $display("FAIL reset_gnt_ch: got %0d want 0", gnt_ch_o); end
    rst = 1'b0;
    tick();
    n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL reset_first_tie: got %b want 0001", gnt_o); end
    rst = 1'b1;
    tick();
    n_cmp++; if (gnt_o !== 4'b0000 || cyc_o !== 1'b0) begin n_bad++; $display("FAIL reset_abandon: gnt %b cyc %b want 0000/0", gnt_o, cyc_o); end
    rst = 1'b0; req_i = '0;
    tick();
    n_cmp++; if (ack_o !== 4'b0000) begin n_bad++; $display("FAIL reset_no_ack: got %b want 0000", ack_o); end
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0001; pri_i = '0;
    tick();
    n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b want 0001", gnt_o); end
    n_cmp++; if (cyc_o !== 1'b1) begin n_bad++; $display("FAIL single_cyc: got %b want 1", cyc_o); end
    n_cmp++; if (ack_o !== 4'b0000) begin n_bad++; $display("FAIL single_ack_early: got %b want 0000", ack_o); end
    tick();
    n_cmp++; if (ack_o !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b want 0001", ack_o); end
    n_cmp++; if (gnt_o !== 4'b0000 || cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_release: gnt %b cyc %b want 0000/0", gnt_o, cyc_o); end
    n_cmp++; if (full_o !== 4'b0000) begin n_bad++; $display("FAIL single_full: got %b want 0000", full_o); end
    req_i = '0;
    tick();
    n_cmp++; if (ack_o !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pulse: got %b want 0000", ack_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req_i = 4'b1111; pri_i = 16'h3333;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c % 2 == 0) ? (4'b0001 << ((c / 2 - 1) % 4)) : 4'b0000;
      n_cmp++;
      if (ack_o !== exp) begin n_bad++; $display("FAIL rr_ack_c%0d: got %b want %b", c, ack_o, exp); end
    end
    req_i = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req_i = 4'b0011; pri_i = 16'h0092; bus_stall_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++;
      if (gnt_o !== 4'b0010 || gnt_ch_o !== 2'd1 || ack_o !== 4'b0000)
        begin n_bad++; $display("FAIL stall_hold_c%0d: gnt %b ch %0d ack %b want 0010/1/0000", c, gnt_o, gnt_ch_o, ack_o); end
    end
    bus_stall_i = 1'b0;
    tick();
    n_cmp++; if (ack_o !== 4'b0010) begin n_bad++; $display("FAIL stall_ack: got %b want 0010", ack_o); end
    req_i = '0;
    tick();
    n_cmp++; if (ack_o !== 4'b0000) begin n_bad++; $display("FAIL stall_single_ack: got %b want 0000", ack_o); end
  endtask

  task automatic test_maxout();
    int acks;
    acks = 0;
    do_reset();
    req_i = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ack2[2]) acks++;
    end
    n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL maxout_acks: got %0d want 2", acks); end
    n_cmp++; if (full2 !== 4'b0100) begin n_bad++; $display("FAIL maxout_full: got %b want 0100", full2); end
    n_cmp++; if (gnt2 !== 4'b0000) begin n_bad++; $display("FAIL maxout_no_gnt: got %b want 0000", gnt2); end
    resp_ack_i = 1'b1; resp_ch_i = 2'd2;
    tick();
    resp_ack_i = 1'b0;
    n_cmp++; if (full2 !== 4'b0000) begin n_bad++; $display("FAIL maxout_unfull: got %b want 0000", full2); end
    tick();
    n_cmp++; if (gnt2 !== 4'b0100) begin n_bad++; $display("FAIL maxout_resume: got %b want 0100", gnt2); end
    n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL maxout_err: got %b want 0", err2); end
    req_i = '0;
  endtask

  task automatic test_err();
    do_reset();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_initial: got %b want 0", err_o); end
    resp_ack_i = 1'b1; resp_ch_i = 2'd1;
    tick();
    resp_ack_i = 1'b0;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_o); end
    tick(); tick();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err_o); end
  endtask

  task automatic test_starve();
    int cnt1, first1;
    cnt1 = 0; first1 = -1;
    do_reset();
    req_i = 4'b0111; pri_i = 16'h0F0F;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ack_o[1]) begin
        cnt1++;
        if (first1 < 0) first1 = c;
      end
      resp_ack_i = |ack_o;
      resp_ch_i  = ack_o[0] ? 2'd0 : (ack_o[1] ? 2'd1 : 2'd2);
    end
    resp_ack_i = 1'b0; req_i = '0;
`ifdef FTA_REQARB_AGING_EN
    n_cmp++; if (first1 != 32) begin n_bad++; $display("FAIL starve_aged_grant: first ch1 ack at %0d want 32", first1); end
`else
    n_cmp++; if (cnt1 != 0) begin n_bad++; $display("FAIL starve_no_grant: ch1 acks %0d want 0 (first %0d)", cnt1, first1); end
`endif
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL starve_err: got %b want 0", err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_maxout();
    test_err();
    test_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
